cmu: RTL

CMU -- requirements
Module: cmu

---
 rtl/cmu_if.sv | 28 ++
 rtl/cmu.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cmu_if.sv
// Memory-side bus of the cache management unit: one word per request,
// completed by mem_ack_i.
interface cmu_if;
   logic        mem_cs_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_data_o;
   logic [31:0] mem_data_i;
   logic        mem_ack_i;

   modport master (
      output mem_cs_o,
      output mem_we_o,
      output mem_addr_o,
      output mem_data_o,
      input  mem_data_i,
      input  mem_ack_i
   );

   modport slave (
      input  mem_cs_o,
      input  mem_we_o,
      input  mem_addr_o,
      input  mem_data_o,
      output mem_data_i,
      output mem_ack_i
   );
endinterface

// File: rtl/cmu.sv
// Cache management unit: sequences CPU requests against a registered cache
// array, writes back dirty victims and refills lines from memory.
module cmu #(
   parameter int TAG_BITS        = 23,
   parameter int SET_INDEX_WIDTH = 5,
   parameter int LINE_WORDS      = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         addr_rw,
   input  logic                en_r,
   input  logic                en_w,
   input  logic [2:0]          u_b_h_w,
   input  logic [31:0]         data_w,
   output logic [31:0]         data_r,
   output logic                stall,
   output logic [31:0]         cache_addr,
   output logic                cache_load,
   output logic                cache_store,
   output logic                cache_edit,
   output logic                cache_invalid,
   output logic [2:0]          cache_u_b_h_w,
   output logic [31:0]         cache_din,
   input  logic [31:0]         cache_dout,
   input  logic                cache_hit,
   input  logic                cache_valid,
   input  logic                cache_dirty,
   input  logic [TAG_BITS-1:0] cache_tag,
   cmu_if.master               mem
);

   localparam int WORD_W = $clog2(LINE_WORDS);
   localparam int IDX_LO = WORD_W + 2;
   localparam int TAG_LO = IDX_LO + SET_INDEX_WIDTH;
   localparam logic [WORD_W-1:0] LAST_W = WORD_W'(LINE_WORDS - 1);

   typedef enum logic [2:0] {IDLE, CHECK, BACK, FILL, WAIT} state_t;

   state_t                     state, state_nx;
   logic [WORD_W-1:0]          w;
   logic                       ph_b;        // 0: phase A (array read), 1: phase B (memory write)
   logic [31:0]                req_addr;
   logic [2:0]                 req_ubhw;
   logic [31:0]                req_data;
   logic                       req_we;
   logic [TAG_BITS-1:0]        victim_tag;

   logic                       req_in;
   logic [SET_INDEX_WIDTH-1:0] req_idx;
   logic [TAG_BITS-1:0]        req_tag;
   logic [31:0]                fill_addr;
   logic [31:0]                wb_addr;
   logic [31:0]                back_addr;

   assign req_in    = en_r | en_w;
   assign req_idx   = req_addr[IDX_LO +: SET_INDEX_WIDTH];
   assign req_tag   = req_addr[TAG_LO +: TAG_BITS];
   assign fill_addr = {req_tag, req_idx, w, 2'b00};
   assign wb_addr   = {victim_tag, req_idx, w, 2'b00};
   // The array is indexed by set and word only when reading out the victim.
   assign back_addr = {{TAG_BITS{1'b0}}, req_idx, w, 2'b00};

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Request latch, victim tag capture and the per-line word counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         w          <= '0;
         ph_b       <= 1'b0;
         req_addr   <= '0;
         req_ubhw   <= '0;
         req_data   <= '0;
         req_we     <= 1'b0;
         victim_tag <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_in) begin
                  req_addr <= addr_rw;
                  req_ubhw <= u_b_h_w;
                  req_data <= data_w;
                  req_we   <= en_w;
               end
            end
            CHECK: begin
               w    <= '0;
               ph_b <= 1'b0;
               if (!cache_hit && cache_valid && cache_dirty) victim_tag <= cache_tag;
            end
            BACK: begin
               if (!ph_b) begin
                  ph_b <= 1'b1;
               end else if (mem.mem_ack_i) begin
                  ph_b <= 1'b0;
                  w    <= w + WORD_W'(1);
               end
            end
            FILL: begin
               if (mem.mem_ack_i) w <= w + WORD_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Next-state selection.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (req_in) state_nx = CHECK;
         CHECK: begin
            if (cache_hit)                      state_nx = IDLE;
            else if (cache_valid && cache_dirty) state_nx = BACK;
            else                                 state_nx = FILL;
         end
         BACK:  if (ph_b && mem.mem_ack_i && w == LAST_W) state_nx = FILL;
         FILL:  if (mem.mem_ack_i && w == LAST_W)         state_nx = WAIT;
         WAIT:  state_nx = CHECK;
         default: state_nx = IDLE;
      endcase
   end

   // Cache array, CPU and memory outputs decoded from the current state.
   always_comb begin
      data_r         = '0;
      stall          = 1'b0;
      cache_addr     = '0;
      cache_load     = 1'b0;
      cache_store    = 1'b0;
      cache_edit     = 1'b0;
      cache_invalid  = 1'b0;
      cache_u_b_h_w  = '0;
      cache_din      = '0;
      mem.mem_cs_o   = 1'b0;
      mem.mem_we_o   = 1'b0;
      mem.mem_addr_o = '0;
      mem.mem_data_o = '0;
      case (state)
         IDLE: begin
            cache_u_b_h_w = u_b_h_w;
            cache_din     = data_w;
            if (req_in) begin
               stall      = 1'b1;
               cache_addr = addr_rw;
               cache_load = en_r & ~en_w;
               cache_edit = en_w;
            end
         end
         CHECK: begin
            cache_addr    = req_addr;
            cache_u_b_h_w = req_ubhw;
            stall         = ~cache_hit;
            if (cache_hit && !req_we) data_r = cache_dout;
         end
         BACK: begin
            stall      = 1'b1;
            cache_addr = back_addr;
            if (ph_b) begin
               mem.mem_cs_o   = 1'b1;
               mem.mem_we_o   = 1'b1;
               mem.mem_addr_o = wb_addr;
               mem.mem_data_o = cache_dout;
            end
         end
         FILL: begin
            stall          = 1'b1;
            mem.mem_cs_o   = 1'b1;
            mem.mem_addr_o = fill_addr;
            cache_addr     = fill_addr;
            cache_din      = mem.mem_data_i;
            cache_store    = mem.mem_ack_i;
         end
         WAIT: begin
            stall         = 1'b1;
            cache_addr    = req_addr;
            cache_load    = ~req_we;
            cache_edit    = req_we;
            cache_u_b_h_w = req_ubhw;
            cache_din     = req_data;
         end
         default: ;
      endcase
   end

endmodule
